// File: rtl/ram_fifo_pkg.sv
// Shared constants for the RAM-backed FIFO controller around the 16x8 dual-port RAM.
package ram_fifo_pkg;

    localparam int DATA_W       = 8;
    localparam int ADDR_W       = 4;
    localparam int DEPTH        = 2 ** ADDR_W;
    localparam int OUTBUF_DEPTH = 2;
    localparam int OUTBUF_CNT_W = $clog2(OUTBUF_DEPTH + 1);

endpackage

// File: rtl/ram_fifo_outbuf.sv
// Small in-order output buffer that hides the RAM read latency; entry 0 is always the head.
module ram_fifo_outbuf
    import ram_fifo_pkg::*;
(
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_W-1:0]       din,
    output logic [DATA_W-1:0]       dout,
    output logic [OUTBUF_CNT_W-1:0] cnt
);

    logic [DATA_W-1:0]       entry_reg  [OUTBUF_DEPTH];
    logic [DATA_W-1:0]       entry_next [OUTBUF_DEPTH];
    logic [OUTBUF_CNT_W-1:0] cnt_reg;
    logic [OUTBUF_CNT_W-1:0] cnt_next;
    logic [OUTBUF_CNT_W-1:0] wr_pos;

    // A push lands in the first free slot after this cycle's pop has shifted the queue.
    assign wr_pos   = cnt_reg - OUTBUF_CNT_W'(pop);
    assign cnt_next = wr_pos + OUTBUF_CNT_W'(push);

    genvar gi;
    generate
        for (gi = 0; gi < OUTBUF_DEPTH; gi++) begin : g_entry
            logic [DATA_W-1:0] shifted;
            if (gi == OUTBUF_DEPTH - 1) begin : g_last
                assign shifted = '0;
            end else begin : g_mid
                assign shifted = entry_reg[gi+1];
            end
            assign entry_next[gi] = (push && (wr_pos == OUTBUF_CNT_W'(gi))) ? din :
                                    (pop ? shifted : entry_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
            for (int i = 0; i < OUTBUF_DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
        end else begin
            cnt_reg <= cnt_next;
            for (int i = 0; i < OUTBUF_DEPTH; i++) begin
                entry_reg[i] <= entry_next[i];
            end
        end
    end

    assign dout = entry_reg[0];
    assign cnt  = cnt_reg;

endmodule

// File: rtl/ram_fifo_ctrl_16x8.sv
// FIFO controller wrapped around an external 16x8 dual-port RAM with FWFT output.
// Optional build macro RAM_FIFO_BYPASS_EN routes pushes into an idle FIFO straight to the output buffer.
module ram_fifo_ctrl_16x8
    import ram_fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_d_in,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_rd_addr,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_d_out,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    localparam int LVL_W   = ADDR_W + 1;
    localparam int CLAIM_W = OUTBUF_CNT_W + 1;

    logic [ADDR_W-1:0]       wr_ptr_reg;
    logic [ADDR_W-1:0]       rd_ptr_reg;
    logic [LVL_W-1:0]        ram_level_reg;
    logic [LVL_W-1:0]        ram_level_next;
    logic                    inflight_reg;
    logic                    full_reg;

    logic                    push;
    logic                    pop;
    logic                    ram_push;
    logic                    rd_issue;
    logic                    bypass_push;
    logic                    outbuf_push;
    logic [DATA_W-1:0]       outbuf_din;
    logic [DATA_W-1:0]       outbuf_dout;
    logic [OUTBUF_CNT_W-1:0] outbuf_cnt;
    logic [CLAIM_W-1:0]      outbuf_claim;

    assign s_ready = !full_reg && !rst;
    assign push    = s_valid && s_ready;
    assign m_valid = (outbuf_cnt != '0);
    assign pop     = m_valid && m_ready;

    // Slots already spoken for once this cycle's pop is taken out; a read is only
    // issued when its data is guaranteed a free slot on arrival.
    assign outbuf_claim = {1'b0, outbuf_cnt} + CLAIM_W'(inflight_reg) - CLAIM_W'(pop);
    assign rd_issue     = !rst && (ram_level_reg != '0) &&
                          (outbuf_claim < CLAIM_W'(OUTBUF_DEPTH));

`ifdef RAM_FIFO_BYPASS_EN
    assign bypass_push = push && (ram_level_reg == '0) && !inflight_reg &&
                         (({1'b0, outbuf_cnt} - CLAIM_W'(pop)) < CLAIM_W'(OUTBUF_DEPTH));
`else
    assign bypass_push = 1'b0;
`endif

    assign ram_push    = push && !bypass_push;
    assign ram_we      = ram_push;
    assign ram_wr_addr = wr_ptr_reg;
    assign ram_d_in    = ram_push ? s_data : '0;
    assign ram_re      = rd_issue;
    assign ram_rd_addr = rd_ptr_reg;

    // Capture and bypass are mutually exclusive: bypass requires nothing in flight.
    assign outbuf_push = inflight_reg || bypass_push;
    assign outbuf_din  = inflight_reg ? ram_d_out : s_data;

    assign ram_level_next = ram_level_reg + LVL_W'(ram_push) - LVL_W'(rd_issue);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            ram_level_reg <= '0;
            inflight_reg  <= 1'b0;
            full_reg      <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_reg + ADDR_W'(ram_push);
            rd_ptr_reg    <= rd_ptr_reg + ADDR_W'(rd_issue);
            ram_level_reg <= ram_level_next;
            inflight_reg  <= rd_issue;
            full_reg      <= (ram_level_next == LVL_W'(DEPTH));
        end
    end

    ram_fifo_outbuf u_outbuf (
        .clk  (clk),
        .srst (rst),
        .push (outbuf_push),
        .pop  (pop),
        .din  (outbuf_din),
        .dout (outbuf_dout),
        .cnt  (outbuf_cnt)
    );

    assign m_data = outbuf_dout;
    assign count  = ram_level_reg + LVL_W'(inflight_reg) + LVL_W'(outbuf_cnt);
    assign empty  = (count == '0);
    assign full   = full_reg;

endmodule

// File: tb/tb_ram_fifo_ctrl_16x8.sv
// Scoreboard bench for ram_fifo_ctrl_16x8 with a behavioural RAM and a queue reference model.
module tb_ram_fifo_ctrl_16x8;
    import ram_fifo_pkg::*;

`ifdef RAM_FIFO_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 3;
`endif

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [DATA_W-1:0] ram_d_in;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic              ram_re;
    logic [DATA_W-1:0] ram_d_out;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] ref_q[$];
    int stall = 0;

    ram_fifo_ctrl_16x8 dut (
        .clk         (clk),
        .rst         (rst),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .ram_wr_addr (ram_wr_addr),
        .ram_d_in    (ram_d_in),
        .ram_we      (ram_we),
        .ram_rd_addr (ram_rd_addr),
        .ram_re      (ram_re),
        .ram_d_out   (ram_d_out),
        .count       (count),
        .full        (full),
        .empty       (empty)
    );

    // Behavioural 16x8 RAM with one-cycle registered read.
    logic [DATA_W-1:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_wr_addr] <= ram_d_in;
        if (ram_re) ram_d_out <= ram_mem[ram_rd_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: compares DUT against the queue model once per cycle, away from the edge.
    always @(negedge clk) begin
        int occ;
        logic [DATA_W-1:0] exp;
        if (rst) begin
            ref_q.delete();
            stall = 0;
        end else begin
            occ = ref_q.size();
            check("count", 32'(count), 32'(occ));
            check("empty", 32'(empty), 32'(occ == 0));
            check("s_ready_vs_full", 32'(s_ready), 32'(!full));
            if (occ < DEPTH) check("full_low_occ", 32'(full), 32'd0);
            if (occ == DEPTH + 2) check("full_max_occ", 32'(full), 32'd1);
            if (occ == 0) check("m_valid_when_empty", 32'(m_valid), 32'd0);
            if (ram_we && ram_re) check("rw_addr_clash", 32'(ram_wr_addr == ram_rd_addr), 32'd0);
            if (occ > 0 && !m_valid) stall++;
            else stall = 0;
            check("head_latency", 32'(stall > 3), 32'd0);
            if (m_valid && m_ready && occ > 0) begin
                exp = ref_q.pop_front();
                check("m_data", 32'(m_data), 32'(exp));
                $display("pop  data=%02h expected=%02h count=%0d", m_data, exp, count);
            end
            if (s_valid && s_ready) begin
                ref_q.push_back(s_data);
                $display("push data=%02h count=%0d", s_data, count);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (empty) break;
            tick();
        end
        check(tag, 32'(empty), 32'd1);
        tick();
        m_ready = 1'b0;
    endtask

    initial begin
        int nxt;
        int pops;
        int first_pop;
        int last_pop;

        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        s_valid = 1'b1; s_data = 8'hFF; m_ready = 1'b1;
        @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_data", 32'(m_data), 0);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_ram_re", 32'(ram_re), 0);
        check("rst_wr_addr", 32'(ram_wr_addr), 0);
        check("rst_rd_addr", 32'(ram_rd_addr), 0);
        check("rst_d_in", 32'(ram_d_in), 0);
        check("rst_count", 32'(count), 0);
        check("rst_full", 32'(full), 0);
        check("rst_empty", 32'(empty), 1);

        // Single word latency
        tick();
        rst = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        @(negedge clk);
        check("s_ready_after_rst", 32'(s_ready), 1);
        tick();
        s_valid = 1'b1; s_data = 8'hA5;
        @(negedge clk);
        check("t0_ram_we", 32'(ram_we), 32'(LAT == 3));
        check("t0_wr_addr", 32'(ram_wr_addr), 0);
        check("t0_d_in", 32'(ram_d_in), (LAT == 3) ? 32'hA5 : 32'h0);
        tick();
        s_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("t1_ram_re", 32'(ram_re), 32'(LAT == 3));
                check("t1_rd_addr", 32'(ram_rd_addr), 0);
            end
            check("latency_m_valid", 32'(m_valid), 32'(c >= LAT));
            if (c >= LAT) check("latency_m_data", 32'(m_data), 32'hA5);
            if (c < 3) tick();
        end
        tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;

        // Fill to capacity with the sink stalled
        nxt = 0;
        s_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            s_data = 8'(nxt);
            @(negedge clk);
            if (s_valid && s_ready) nxt++;
            tick();
        end
        s_data = 8'(nxt);
        check("fill_accepted", 32'(nxt), 32'(DEPTH + 2));
        @(negedge clk);
        check("fill_count", 32'(count), 32'(DEPTH + 2));
        check("fill_full", 32'(full), 1);
        check("fill_s_ready", 32'(s_ready), 0);

        // Full with simultaneous push attempt and pop
        tick();
        m_ready = 1'b1;
        @(negedge clk);
        check("fullpop_s_ready", 32'(s_ready), 0);
        check("fullpop_ram_re", 32'(ram_re), 1);
        tick();
        m_ready = 1'b0;
        @(negedge clk);
        check("fullpop_s_ready_next", 32'(s_ready), 1);
        tick();
        drain("fill_drain_empty");

        // Streaming, both sides always ready
        nxt = 0; pops = 0; first_pop = -1; last_pop = -1;
        m_ready = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            s_valid = (nxt < 40);
            s_data  = 8'(8'h40 + nxt);
            @(negedge clk);
            if (s_valid && s_ready) nxt++;
            if (m_valid && m_ready) begin
                pops++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            tick();
            if (pops == 40) break;
        end
        s_valid = 1'b0;
        check("stream_pops", 32'(pops), 40);
        check("stream_no_bubbles", 32'(last_pop - first_pop + 1), 40);
        drain("stream_drain_empty");

        // Reset while a RAM read is in flight
        nxt = 0;
        s_valid = 1'b1;
        for (int i = 0; i < 10 && nxt < 4; i++) begin
            s_data = 8'(8'hC0 + nxt);
            @(negedge clk);
            if (s_valid && s_ready) nxt++;
            tick();
        end
        s_valid = 1'b0;
        repeat (4) tick();
        m_ready = 1'b1;
        @(negedge clk);
        check("inflight_ram_re", 32'(ram_re), 1);
        tick();
        m_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_m_valid", 32'(m_valid), 0);
        check("midrst_count", 32'(count), 0);
        check("midrst_empty", 32'(empty), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("midrst_no_stale", 32'(m_valid), 0);
        end
        tick();

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            s_valid = ($urandom_range(0, 9) < 7);
            s_data  = 8'($urandom);
            m_ready = (i < 200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
            rst     = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0;
        drain("random_drain_empty");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ram_fifo_ctrl_16x8.md
# ram_fifo_ctrl_16x8

Synchronous FIFO controller that wraps the 16x8 dual-port RAM. It sits directly around the RAM: it feeds the write port and read port, and it consumes the RAM's registered read data. It exposes valid/ready streams on both sides, a first-word-fall-through output, and occupancy flags. It owns the pointers, the level accounting and a 2-entry output buffer that hides the RAM's one-cycle read latency.

## Interface
- DATA_W, 8, data width; must match the RAM.
- ADDR_W, 4, RAM address width; RAM depth DEPTH = 2**ADDR_W = 16.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- s_data  in  DATA_W  write-side data.
- s_valid  in  1  write-side valid.
- s_ready  out  1  write-side ready.
- m_data  out  DATA_W  read-side data (head of FIFO).
- m_valid  out  1  read-side valid.
- m_ready  in  1  read-side ready.
- ram_wr_addr  out  ADDR_W  to RAM wr_addr.
- ram_d_in  out  DATA_W  to RAM d_in.
- ram_we  out  1  to RAM we.
- ram_rd_addr  out  ADDR_W  to RAM rd_addr.
- ram_re  out  1  to RAM re.
- ram_d_out  in  DATA_W  from RAM d_out; valid the cycle after a sampled ram_re.
- count  out  ADDR_W+1  total occupancy: RAM level + in-flight read + output buffer, range 0..DEPTH+2.
- full  out  1  RAM level == DEPTH.
- empty  out  1  count == 0.

## Operation
- Push happens when s_valid & s_ready. The controller then drives ram_we=1, ram_wr_addr=wr_ptr and ram_d_in=s_data in the same cycle; wr_ptr and ram_level increment at the edge.
- s_ready = !full & !rst. full is registered.
- Pop happens when m_valid & m_ready. The output buffer drops its head at the edge.
- Read issue: ram_re=1 with ram_rd_addr=rd_ptr when ram_level>0 and (outbuf_cnt + inflight - pop) < 2. At the edge: rd_ptr increments, ram_level decrements, inflight is set.
- Capture: when inflight=1, ram_d_out is written into the output buffer at the edge and inflight clears.
- Pointers wrap modulo DEPTH (15 -> 0). ram_level is ADDR_W+1 bits wide (0..16).
- A read and a write never target the same address in the same cycle. A read needs ram_level>0; at ram_level==DEPTH writes are blocked.
- Simultaneous push and read issue: ram_level stays unchanged.
- Simultaneous push and pop with the FIFO full: the pop frees output-buffer space only. s_ready stays 0 until ram_level < DEPTH.
- Output buffer is a 2-entry FIFO, in order. m_data = head entry. m_valid = outbuf_cnt > 0.
- Reset (including mid-operation): pointers, level, inflight and buffer all clear, and any in-flight read data is discarded. The RAM contents are don't-care.

## Timing
- Reset values: s_ready=0, m_valid=0, m_data=0, ram_we=0, ram_re=0, ram_wr_addr=0, ram_rd_addr=0, ram_d_in=0, count=0, full=0, empty=1. s_ready rises the cycle after rst falls.
- Push-to-m_valid latency into an empty FIFO is 3 cycles: push in cycle t, ram_re in t+1, ram_d_out valid in t+2, m_valid in t+3.
- Steady-state throughput is 1 push and 1 pop per cycle, with no bubbles once the output buffer is primed.
- m_data/m_valid are registered. ram_we/ram_re/addresses are combinational from registered state, s_valid and m_ready.
- count, full and empty update at the edge following the event.

## Configuration
- RAM_FIFO_BYPASS_EN defined: a push when ram_level==0, inflight==0 and outbuf_cnt < 2 (after this cycle's pop) writes s_data straight into the output buffer. ram_we stays 0 for that push, and latency is 1 cycle (m_valid in t+1).
- RAM_FIFO_BYPASS_EN undefined: every word passes through the RAM, with the 3-cycle latency above.
- In both builds the ordering, count and flags are identical.

## Structure
- Package ram_fifo_pkg holds DATA_W, ADDR_W, DEPTH and the OUTBUF_DEPTH=2 constant.
- Sub-module ram_fifo_outbuf is the 2-entry output buffer: push, pop, data in/out and cnt.
- The RAM itself is instantiated by the parent, not inside this block.

## Test plan
- Reset with an empty FIFO: push 0xA5 in cycle 0 -> ram_we=1 at addr 0, ram_re at addr 0 in cycle 1, m_valid=1 and m_data=0xA5 in cycle 3. With the bypass build, m_valid=1 in cycle 1.
- Fill with m_ready=0: push 0x00..0x11 (18 words) -> count reaches 18, full=1, s_ready=0. A 19th push attempt is not accepted. Draining returns 0x00..0x11 in order, then empty=1.
- Streaming with s_valid=m_ready=1 for 40 words -> after priming, exactly 1 word out per cycle, in order. Pointers wrap past 15 with no data loss.
- Full plus simultaneous push/pop: s_ready stays 0. One pop from the buffer causes a RAM read, ram_level drops to 15, and s_ready=1 on the next cycle.
- Assert rst while a read is in flight (ram_re issued the previous cycle) -> the next cycle has m_valid=0, count=0, empty=1. Stale ram_d_out is never presented.
